modsub_resq: RTL and testbench

Result-collection stage directly downstream of the pipelined modular subtractor (`modsub`). `modsub` has a fixed latency and no valid or backpressure signals. This block handles both:
- It tracks which core output cycles carry real results, with a tag shift register aligned to the core latency.
- It captures those results into a small FIFO and exposes a valid/ready output.
- It grants issue credits upstream, so a result accepted into the core can never be dropped.

---
 rtl/modop_pkg.sv | 17 +
 rtl/modop_fifo.sv | 50 +++++
 rtl/modsub_resq.sv | 67 ++++++
 tb/tb_modsub_resq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/modop_pkg.sv
// Shared definitions for the modular-op result collectors (modadd/modsub/modmul).
package modop_pkg;

    localparam int LOGQ_DEF = 64;
    localparam int TAGW_DEF = 8;

    typedef struct packed {
        logic                valid;
        logic [TAGW_DEF-1:0] tag;
    } modop_trk_t;

    // Core latency is the sum of its register stages.
    function automatic int modop_lat(input int ff_in, input int ff_sub, input int ff_out);
        return ff_in + ff_sub + ff_out;
    endfunction

endpackage

// File: rtl/modop_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; head reads 0 when empty.
module modop_fifo #(
    parameter  int W     = 72,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic          head_valid,
    output logic [W-1:0]  head_data,
    output logic          full,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          do_push, do_pop;

    assign head_valid = (count != '0);
    assign full       = (count == CW'(DEPTH));
    assign do_push    = push && !full;
    assign do_pop     = pop && head_valid;
    assign head_data  = head_valid ? mem[rptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_data;
    end

    // Power-of-2 depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/modsub_resq.sv
// Result collector for the fixed-latency modsub core: tags in-flight ops, queues results, grants credits.
module modsub_resq
    import modop_pkg::*;
#(
    parameter  int LOGQ  = LOGQ_DEF,
    parameter  int LAT   = 3,
    parameter  int TAGW  = TAGW_DEF,
    parameter  int DEPTH = 8,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [TAGW-1:0] issue_tag,
    output logic            issue_ready,
    input  logic [LOGQ-1:0] core_C,
    output logic            out_valid,
    output logic [LOGQ-1:0] out_data,
    output logic [TAGW-1:0] out_tag,
    input  logic            out_ready,
    output logic [LW-1:0]   level
);

    logic [LAT:1]           vld_pipe;
    logic [LAT:1][TAGW-1:0] tag_pipe;
    logic                   accept, full;
    logic [LOGQ+TAGW-1:0]   head;

    // Queued plus in-flight must stay below DEPTH; a pop this cycle is credited next cycle.
    assign issue_ready = (int'(level) + $countones(vld_pipe)) < DEPTH;
    assign accept      = issue_valid && issue_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            vld_pipe[1] <= accept;
            tag_pipe[1] <= issue_tag;
            for (int k = 2; k <= LAT; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                tag_pipe[k] <= tag_pipe[k-1];
            end
        end
    end

    modop_fifo #(
        .W     (LOGQ + TAGW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst),
        .push       (vld_pipe[LAT]),
        .push_data  ({core_C, tag_pipe[LAT]}),
        .pop        (out_ready),
        .head_valid (out_valid),
        .head_data  (head),
        .full       (full),
        .count      (level)
    );

    assign {out_data, out_tag} = head;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(vld_pipe[LAT] && full))
        else $error("modsub_resq: result pushed into a full queue");

endmodule

// File: tb/tb_modsub_resq.sv
// Directed bench for modsub_resq with a queue-based model of issue credit and result ordering.
module tb_modsub_resq;
    import modop_pkg::*;

    localparam int LOGQ  = 64;
    localparam int TAGW  = 8;
    localparam int DEPTH = 8;
    localparam int LAT   = modop_lat(1, 1, 1);
    localparam int LW    = $clog2(DEPTH + 1);

    logic            clk = 0;
    logic            rst = 1;
    logic            issue_valid = 0;
    logic [TAGW-1:0] issue_tag = '0;
    logic            issue_ready;
    logic [LOGQ-1:0] core_C = '0;
    logic            out_valid;
    logic [LOGQ-1:0] out_data;
    logic [TAGW-1:0] out_tag;
    logic            out_ready = 0;
    logic [LW-1:0]   level;

    logic [LOGQ-1:0] issue_res = '0;   // result the model core will produce for the current issue

    modsub_resq #(.LOGQ(LOGQ), .LAT(LAT), .TAGW(TAGW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_tag(issue_tag),
        .issue_ready(issue_ready), .core_C(core_C), .out_valid(out_valid),
        .out_data(out_data), .out_tag(out_tag), .out_ready(out_ready), .level(level)
    );

    typedef struct {
        logic [LOGQ-1:0] data;
        logic [TAGW-1:0] tag;
        int              rdy;   // first cycle the result may be visible at the output
    } exp_t;

    exp_t            q[$];
    logic [LOGQ-1:0] due[int];
    int              outstanding = 0;
    int              beats = 0;
    int              last_pop = -1;
    int              cyc = 0;
    int              errors = 0;
    int              checks = 0;
    bit              mon_on = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model core: aligned cycles carry the scheduled result, every other cycle carries garbage.
    always @(posedge clk) begin
        #1;
        if (due.exists(cyc)) core_C = due[cyc];
        else                 core_C = {32'hDEADBEEF, 32'(cyc)};
    end

    // Compare process: every cycle, outputs against the model, then advance the model.
    bit ev, er;
    int lv;
    always @(negedge clk) begin
        if (mon_on) begin
            lv = 0;
            foreach (q[i]) if (q[i].rdy <= cyc) lv++;
            ev = (q.size() > 0) && (q[0].rdy <= cyc);
            er = (outstanding < DEPTH);
            chk("issue_ready", 64'(issue_ready), 64'(er));
            chk("out_valid", 64'(out_valid), 64'(ev));
            chk("level", 64'(level), 64'(lv));
            if (ev) begin
                chk("out_data", out_data, q[0].data);
                chk("out_tag", 64'(out_tag), 64'(q[0].tag));
            end
            if (rst && issue_valid && er) begin
                q.push_back('{data: issue_res, tag: issue_tag, rdy: cyc + LAT + 1});
                due[cyc + LAT] = issue_res;
                outstanding++;
            end
            if (ev && out_ready) begin
                void'(q.pop_front());
                outstanding--;
                beats++;
                last_pop = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, b0;
        #2 rst = 0;
        repeat (2) tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        rst = 1;
        mon_on = 1;

        // single issue, tag 0x11, core result 5
        chk("t1_ready_first", 64'(issue_ready), 64'd1);
        t0 = cyc;
        issue_valid = 1; issue_tag = 8'h11; issue_res = 64'h5;
        for (int k = 1; k <= LAT + 1; k++) begin
            tick();
            issue_valid = 0;
            chk("t1_ready", 64'(issue_ready), 64'd1);
            if (k <= LAT) chk("t1_not_yet", 64'(out_valid), 64'd0);
        end
        chk("t1_cycle", 64'(cyc - t0), 64'd4);
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_data", out_data, 64'h0000000000000005);
        chk("t1_tag", 64'(out_tag), 64'h11);
        out_ready = 1;
        tick();

        // 20 back-to-back issues, full throughput
        b0 = beats; t0 = cyc;
        for (int i = 0; i < 20; i++) begin
            issue_valid = 1; issue_tag = 8'(i); issue_res = 64'(i * 3);
            chk("t2_ready", 64'(issue_ready), 64'd1);
            tick();
        end
        issue_valid = 0;
        repeat (LAT + 1) tick();
        chk("t2_beats", 64'(beats - b0), 64'd20);
        chk("t2_last_pop", 64'(last_pop - t0), 64'd23);
        chk("t2_level", 64'(level), 64'd0);

        // consumer stalled: credits run out at DEPTH
        out_ready = 0;
        for (int i = 0; i < 12; i++) begin
            issue_valid = 1; issue_tag = 8'(8'h40 + i); issue_res = 64'(16'h1000 + i);
            tick();
        end
        chk("t3_level_full", 64'(level), 64'd8);
        chk("t3_ready_low", 64'(issue_ready), 64'd0);
        out_ready = 1;
        chk("t3_pop_not_credited", 64'(issue_ready), 64'd0);
        tick();
        out_ready = 0;
        chk("t3_level_after_pop", 64'(level), 64'd7);
        chk("t3_ready_after_pop", 64'(issue_ready), 64'd1);
        tick();
        chk("t3_ready_again_low", 64'(issue_ready), 64'd0);
        issue_valid = 0; out_ready = 1;
        repeat (14) tick();
        chk("t3_drained", 64'(level), 64'd0);

        // alternating bubbles, garbage on unaligned core cycles
        b0 = beats;
        for (int i = 0; i < 10; i++) begin
            issue_valid = (i % 2 == 0); issue_tag = 8'(8'h80 + i); issue_res = 64'(16'h5500 + i);
            tick();
        end
        issue_valid = 0;
        repeat (6) tick();
        chk("t4_beats", 64'(beats - b0), 64'd5);

        // async reset with 3 queued and 2 in flight
        out_ready = 0;
        for (int n = 0; n < 5; n++) begin
            issue_valid = 1; issue_tag = 8'(8'hA0 + n); issue_res = 64'(16'h7700 + n);
            tick();
        end
        issue_valid = 0;
        tick();
        chk("t5_level_before", 64'(level), 64'd3);
        @(negedge clk);
        #2;
        rst = 0;
        q.delete();
        outstanding = 0;
        #1;
        chk("t5_valid_now", 64'(out_valid), 64'd0);
        chk("t5_level_now", 64'(level), 64'd0);
        tick();
        rst = 1;
        out_ready = 1;
        b0 = beats;
        repeat (6) tick();
        chk("t5_no_stale", 64'(beats - b0), 64'd0);
        chk("t5_level_after", 64'(level), 64'd0);

        // steady push+pop at level 1
        for (int i = 0; i < 14; i++) begin
            issue_valid = 1; issue_tag = 8'(8'hC0 + i); issue_res = 64'h0000_0000_CAFE_0000 + 64'(i);
            tick();
            if (i >= 3 && i <= 12) chk("t6_level_one", 64'(level), 64'd1);
        end
        issue_valid = 0;
        repeat (6) tick();
        chk("t6_drained", 64'(level), 64'd0);

        mon_on = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
